pipe_stage_buffer: RTL and testbench

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

---
 rtl/pipe_stage_buffer_if.sv | 31 +++
 rtl/pipe_stage_buffer.sv | 136 +++++++++++++
 tb/tb_pipe_stage_buffer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buffer_if.sv
`default_nettype none
// ============================================================================
// pipe_stage_buffer_if : upstream/downstream handshake bundle for the buffer
// Revision: 1.0
// ============================================================================
interface pipe_stage_buffer_if #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // Driver of the upstream side and consumer of the downstream side.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // The buffer itself.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// pipe_stage_buffer : two-entry (main + skid) pipeline stage register with flush,
// bubble control gating and optional PIPE_STAGE_STALL_CNT_EN stall counter.
// Revision: 1.0
// ============================================================================
module pipe_stage_buffer #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 24
) (
  input  wire logic             Clk,
  input  wire logic             Rst_n,
  input  wire logic             flush,
  pipe_stage_buffer_if.slave    bus
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output      logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;

  logic              w_out_valid;
  logic              w_accept;
  logic              w_consume;

  assign w_out_valid = (state_q != ST_EMPTY);
  assign w_accept    = bus.in_valid & in_ready_q;
  assign w_consume   = w_out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = w_out_valid ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          state_d     = ST_ONE;
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end
      end
      ST_ONE: begin
        if (w_accept && w_consume) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end else if (w_accept) begin
          state_d     = ST_TWO;
          skid_data_d = bus.in_data;
          skid_ctrl_d = bus.in_ctrl;
        end else if (w_consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_consume) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins: drop everything and ignore any entry offered this cycle.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
    end

    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_out_valid && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_buffer : directed stimulus, queue-based reference model and
// per-cycle comparison for pipe_stage_buffer.
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_buffer;
  localparam int DW = 48;
  localparam int CW = 24;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;
  logic flush = 1'b0;

  pipe_stage_buffer_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of at most two entries.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  entry_t        m_q[$];
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_last  = '0;
  int            m_stall = 0;
  bit            m_acc, m_cons;
  entry_t        m_new;

  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_q.delete();
      m_ready = 1'b1;
      m_last  = '0;
      m_stall = 0;
    end else begin
      m_acc  = bus.in_valid && m_ready;
      m_cons = (m_q.size() > 0) && bus.out_ready;
      if ((m_q.size() > 0) && !bus.out_ready && (m_stall < 65535)) m_stall++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (m_cons) void'(m_q.pop_front());
        if (m_acc) begin
          m_new = {bus.in_data, bus.in_ctrl};
          m_q.push_back(m_new);
        end
      end
      m_ready = (m_q.size() < 2);
      if (m_q.size() > 0) m_last = m_q[0].d;
    end
  end

  always @(posedge Clk) begin
    check("cmp_out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
    check("cmp_in_ready",  64'(bus.in_ready),  64'(m_ready));
    check("cmp_out_ctrl",  64'(bus.out_ctrl),  (m_q.size() > 0) ? 64'(m_q[0].c) : 64'd0);
    check("cmp_out_data",  64'(bus.out_data),  (m_q.size() > 0) ? 64'(m_q[0].d) : 64'(m_last));
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("cmp_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #1 Rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    tick();
    tick();
    Rst_n = 1'b1;

    // Streaming 1..8 with out_ready held high
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i);
      bus.in_ctrl  = CW'(i * 257);
      tick();
      check("stream_data",     64'(bus.out_data),  64'(i));
      check("stream_valid",    64'(bus.out_valid), 64'd1);
      check("stream_in_ready", 64'(bus.in_ready),  64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("drain_data",  64'(bus.out_data),  64'd8);

    // Backpressure: A then B with out_ready low
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'hA0A0_0000_000A;
    bus.in_ctrl   = 24'h000111;
    tick();
    bus.in_data   = 48'h0000_0000_0B0B;
    bus.in_ctrl   = 24'hFFFFFF;
    tick();
    check("bp_in_ready", 64'(bus.in_ready),  64'd0);
    check("bp_valid",    64'(bus.out_valid), 64'd1);
    check("bp_data_a",   64'(bus.out_data),  64'hA0A0_0000_000A);
    check("bp_ctrl_a",   64'(bus.out_ctrl),  64'h111);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_data_b",   64'(bus.out_data),  64'h0B0B);
    check("bp_ctrl_b",   64'(bus.out_ctrl),  64'hFFFFFF);
    check("bp_ready_up", 64'(bus.in_ready),  64'd1);
    tick();
    check("bubble_valid", 64'(bus.out_valid), 64'd0);
    check("bubble_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("bubble_data",  64'(bus.out_data),  64'h0B0B);

    // Flush collision in TWO
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'hD;
    bus.in_ctrl   = 24'h00000D;
    tick();
    bus.in_data   = 48'hE;
    bus.in_ctrl   = 24'h00000E;
    tick();
    check("fl_two_ready", 64'(bus.in_ready), 64'd0);
    flush         = 1'b1;
    bus.in_data   = 48'hC;
    bus.in_ctrl   = 24'h000333;
    tick();
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("fl_ready", 64'(bus.in_ready),  64'd1);
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_c_valid", 64'(bus.out_valid), 64'd0);
      check("fl_no_c_data",  64'(bus.out_data),  64'hD);
    end

    // Flush in ONE with simultaneous accept and consume
    bus.in_valid = 1'b1;
    bus.in_data  = 48'h11;
    bus.in_ctrl  = 24'h000011;
    tick();
    check("fl1_data", 64'(bus.out_data), 64'h11);
    flush        = 1'b1;
    bus.in_data  = 48'h12;
    tick();
    check("fl1_valid", 64'(bus.out_valid), 64'd0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-cycle while in TWO
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'h21;
    bus.in_ctrl   = 24'h000021;
    tick();
    bus.in_data   = 48'h22;
    bus.in_ctrl   = 24'h000022;
    tick();
    bus.in_valid  = 1'b0;
    check("ar_two_ready", 64'(bus.in_ready), 64'd0);
    #2 Rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(bus.out_valid), 64'd0);
    check("ar_in_ready",  64'(bus.in_ready),  64'd1);
    check("ar_out_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("ar_out_data",  64'(bus.out_data),  64'd0);
    tick();
    Rst_n         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'h31;
    bus.in_ctrl   = 24'h000031;
    bus.out_ready = 1'b1;
    tick();
    check("ar_first_data",  64'(bus.out_data),  64'h31);
    check("ar_first_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    tick();

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter saturation
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'h41;
    bus.in_ctrl   = 24'h000041;
    tick();
    bus.in_valid  = 1'b0;
    repeat (70000) tick();
    check("stall_sat", 64'(stall_cnt), 64'hFFFF);
    repeat (3) tick();
    check("stall_hold", 64'(stall_cnt), 64'hFFFF);
    bus.out_ready = 1'b1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
